sync_fifo_param: RTL and testbench

- Parametrised single-clock FIFO; next generation of the fixed 512x16 sensor-capture FIFO.
- Behavioural RAM inferred to 8K block RAM. Adds run-time flush, programmable almost-full/almost-empty thresholds, sticky overflow/underflow, optional output register and exact fill count.
- Sits between sensor/ADC capture logic (push side) and the bus/DMA reader (pop side) in the same clock domain.

---
 rtl/sync_fifo_param.sv | 230 +++++++++++++++++++++++
 tb/tb_sync_fifo_param.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with level flags and optional output register
//
// Buffers capture words from the sensor/ADC side until the bus/DMA reader
// pops them. Both sides share one clock. Storage is a behavioural RAM that
// maps onto block RAM: one write port and one synchronous, registered read port.
//
// Ports:
//   Clk           sole clock, rising edge
//   Rst           synchronous active-high reset, overrides everything
//   Clk_En        global enable; 0 freezes all state (Rst still acts)
//   Fifo_Flush    synchronous flush; clears like Rst but DOUT holds
//   PUSH / DIN    write request and write word
//   POP           read request
//   DOUT          read word; holds between pops
//   DOUT_VLD      one-cycle strobe marking a new word on DOUT
//   COUNT         exact fill level, 0..depth
//   PUSH_FLAG     free-space level code (15 = completely free)
//   POP_FLAG      fill level code (15 = full)
//   Almost_Full   COUNT >= AF_THRESH
//   Almost_Empty  COUNT <= AE_THRESH
//   Full / Empty  COUNT == depth / COUNT == 0
//   Overflow      sticky: a push was refused
//   Underflow     sticky: a pop was refused

module sync_fifo_param #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9,
    parameter int REG_RD     = 0,
    parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 4,
    parameter int AE_THRESH  = 4
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Clk_En,
    input  logic                  Fifo_Flush,
    input  logic                  PUSH,
    input  logic [DATA_WIDTH-1:0] DIN,
    input  logic                  POP,
    output logic [DATA_WIDTH-1:0] DOUT,
    output logic                  DOUT_VLD,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic [3:0]            PUSH_FLAG,
    output logic [3:0]            POP_FLAG,
    output logic                  Almost_Full,
    output logic                  Almost_Empty,
    output logic                  Full,
    output logic                  Empty,
    output logic                  Overflow,
    output logic                  Underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Count is one bit wider than the pointers so that "depth" itself fits.
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   AF_LVL    = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0]   AE_LVL    = (ADDR_WIDTH+1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   next_count;
    logic [ADDR_WIDTH:0]   next_free;
    logic                  full_q;
    logic                  empty_q;
    logic                  af_q;
    logic                  ae_q;
    logic [3:0]            push_flag_q;
    logic [3:0]            pop_flag_q;
    logic                  ovf_q;
    logic                  udf_q;

    logic                  push_ok;
    logic                  pop_ok;
    logic                  advance;
    logic                  clear;

    // First read stage: the RAM output register and its strobe.
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  ram_vld;

    // Level code: 0 for zero, 15 for a full depth, otherwise the bit length
    // of n (floor(log2 n) + 1) capped at 14.
    function automatic logic [3:0] level_code(input logic [ADDR_WIDTH:0] n);
        logic [3:0] code;
        code = 4'd0;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            if (n[i]) begin
                code = 4'(i + 1);
            end
        end
        if (n == DEPTH_CNT) begin
            code = 4'd15;
        end else if (code > 4'd14) begin
            code = 4'd14;
        end
        return code;
    endfunction

    // A push into a full FIFO is still accepted when a pop frees the slot
    // in the same cycle.
    assign push_ok = PUSH & (~full_q | POP);
    assign pop_ok  = POP & ~empty_q;

    // Normal push/pop activity happens only when enabled and not flushing.
    assign advance = ~Rst & Clk_En & ~Fifo_Flush;
    // Reset and flush clear the same control state.
    assign clear   = Rst | (Clk_En & Fifo_Flush);

    always_comb begin
        next_count = count_q;
        if (push_ok && !pop_ok) begin
            next_count = count_q + CNT_ONE;
        end else if (!push_ok && pop_ok) begin
            next_count = count_q - CNT_ONE;
        end
    end

    assign next_free = DEPTH_CNT - next_count;

    // Pointers, count and all level flags. Flags are computed from the next
    // count so they line up with COUNT in the same cycle.
    always_ff @(posedge Clk) begin
        if (clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            af_q        <= (AF_LVL == '0);
            ae_q        <= 1'b1;
            pop_flag_q  <= 4'd0;
            push_flag_q <= 4'd15;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else if (Clk_En) begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count_q     <= next_count;
            full_q      <= (next_count == DEPTH_CNT);
            empty_q     <= (next_count == '0);
            af_q        <= (next_count >= AF_LVL);
            ae_q        <= (next_count <= AE_LVL);
            pop_flag_q  <= level_code(next_count);
            push_flag_q <= level_code(next_free);
            if (PUSH && !push_ok) begin
                ovf_q <= 1'b1;
            end
            if (POP && !pop_ok) begin
                udf_q <= 1'b1;
            end
        end
    end

    // Storage. No reset so it maps onto block RAM; contents survive Rst.
    always_ff @(posedge Clk) begin
        if (advance && push_ok) begin
            mem[wr_ptr] <= DIN;
        end
    end

    // Read port. Reading in a separate process from the write gives
    // read-before-write: a simultaneous push to the slot being popped
    // returns the old word.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ram_q   <= '0;
            ram_vld <= 1'b0;
        end else if (Clk_En) begin
            if (Fifo_Flush) begin
                ram_vld <= 1'b0;
            end else begin
                ram_vld <= pop_ok;
                if (pop_ok) begin
                    ram_q <= mem[rd_ptr];
                end
            end
        end
    end

    generate
        if (REG_RD != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] dout_q;
            logic                  dout_vld_q;

            // A flush kills a word already in the RAM stage; DOUT keeps
            // the last word actually delivered.
            always_ff @(posedge Clk) begin
                if (Rst) begin
                    dout_q     <= '0;
                    dout_vld_q <= 1'b0;
                end else if (Clk_En) begin
                    if (Fifo_Flush) begin
                        dout_vld_q <= 1'b0;
                    end else begin
                        dout_vld_q <= ram_vld;
                        if (ram_vld) begin
                            dout_q <= ram_q;
                        end
                    end
                end
            end

            assign DOUT     = dout_q;
            assign DOUT_VLD = dout_vld_q;
        end else begin : g_no_out_reg
            assign DOUT     = ram_q;
            assign DOUT_VLD = ram_vld;
        end
    endgenerate

    assign COUNT        = count_q;
    assign PUSH_FLAG    = push_flag_q;
    assign POP_FLAG     = pop_flag_q;
    assign Almost_Full  = af_q;
    assign Almost_Empty = ae_q;
    assign Full         = full_q;
    assign Empty        = empty_q;
    assign Overflow     = ovf_q;
    assign Underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - self-checking bench for sync_fifo_param
module tb_sync_fifo_param;

    localparam int DEPTH = 512;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance: 512 x 16, REG_RD = 0
    logic        rst, en, flush, push, pop;
    logic [15:0] din, dout;
    logic        vld, af, ae, full, empty, ovf, udf;
    logic [9:0]  count;
    logic [3:0]  push_flag, pop_flag;

    sync_fifo_param dut_a (
        .Clk(clk), .Rst(rst), .Clk_En(en), .Fifo_Flush(flush),
        .PUSH(push), .DIN(din), .POP(pop), .DOUT(dout), .DOUT_VLD(vld),
        .COUNT(count), .PUSH_FLAG(push_flag), .POP_FLAG(pop_flag),
        .Almost_Full(af), .Almost_Empty(ae), .Full(full), .Empty(empty),
        .Overflow(ovf), .Underflow(udf)
    );

    // Registered-output instance: 16 x 8, REG_RD = 1
    logic       b_rst, b_en, b_flush, b_push, b_pop;
    logic [7:0] b_din, b_dout;
    logic       b_vld, b_af, b_ae, b_full, b_empty, b_ovf, b_udf;
    logic [4:0] b_count;
    logic [3:0] b_push_flag, b_pop_flag;

    sync_fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .REG_RD(1)) dut_b (
        .Clk(clk), .Rst(b_rst), .Clk_En(b_en), .Fifo_Flush(b_flush),
        .PUSH(b_push), .DIN(b_din), .POP(b_pop), .DOUT(b_dout), .DOUT_VLD(b_vld),
        .COUNT(b_count), .PUSH_FLAG(b_push_flag), .POP_FLAG(b_pop_flag),
        .Almost_Full(b_af), .Almost_Empty(b_ae), .Full(b_full), .Empty(b_empty),
        .Overflow(b_ovf), .Underflow(b_udf)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the default instance
    logic [15:0] mq[$];
    logic [15:0] sb[$];
    logic [15:0] m_dout = '0;
    int          m_vld  = 0;
    int          m_ovf  = 0;
    int          m_udf  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int lvl(input int n);
        int k;
        if (n == 0) return 0;
        if (n == DEPTH) return 15;
        k = 0;
        while ((1 << k) <= n) k++;
        return (k > 14) ? 14 : k;
    endfunction

    task automatic cyc(input logic r, input logic e, input logic f,
                       input logic pu, input logic [15:0] d, input logic po);
        bit fresh, pok, uok;
        int sz;
        rst = r; en = e; flush = f; push = pu; din = d; pop = po;
        @(posedge clk);
        fresh = 0;
        if (r) begin
            mq.delete(); sb.delete();
            m_ovf = 0; m_udf = 0; m_dout = '0; m_vld = 0;
        end else if (e) begin
            if (f) begin
                mq.delete();
                m_ovf = 0; m_udf = 0; m_vld = 0;
            end else begin
                pok = po && (mq.size() > 0);
                uok = pu && ((mq.size() < DEPTH) || po);
                if (po && !pok) m_udf = 1;
                if (pu && !uok) m_ovf = 1;
                if (pok) begin
                    sb.push_back(mq.pop_front());
                    fresh = 1;
                end
                if (uok) mq.push_back(d);
                m_vld = pok ? 1 : 0;
            end
        end
        #1;
        if (fresh) m_dout = sb.pop_front();
        sz = mq.size();
        chk("dout",      32'(dout),      32'(m_dout));
        chk("dout_vld",  32'(vld),       m_vld);
        chk("count",     32'(count),     sz);
        chk("empty",     32'(empty),     (sz == 0) ? 1 : 0);
        chk("full",      32'(full),      (sz == DEPTH) ? 1 : 0);
        chk("alm_full",  32'(af),        (sz >= DEPTH - 4) ? 1 : 0);
        chk("alm_empty", 32'(ae),        (sz <= 4) ? 1 : 0);
        chk("pop_flag",  32'(pop_flag),  lvl(sz));
        chk("push_flag", 32'(push_flag), lvl(DEPTH - sz));
        chk("overflow",  32'(ovf),       m_ovf);
        chk("underflow", 32'(udf),       m_udf);
    endtask

    task automatic bcyc(input logic r, input logic f, input logic pu,
                        input logic [7:0] d, input logic po);
        b_rst = r; b_en = 1'b1; b_flush = f; b_push = pu; b_din = d; b_pop = po;
        @(posedge clk);
        #1;
    endtask

    initial begin
        b_rst = 1'b1; b_en = 1'b1; b_flush = 1'b0; b_push = 1'b0; b_pop = 1'b0; b_din = '0;

        // Reset state
        cyc(1, 1, 0, 0, 16'h0, 0);
        cyc(0, 1, 0, 0, 16'h0, 0);

        // Ordered streaming: 16 pushes then 16 pops
        for (int k = 1; k <= 16; k++) cyc(0, 1, 0, 1, 16'(k), 0);
        for (int k = 1; k <= 16; k++) cyc(0, 1, 0, 0, 16'h0, 1);
        cyc(0, 1, 0, 0, 16'h0, 0);

        // Fill to full, overflow, push+pop while full
        for (int k = 0; k < DEPTH; k++) cyc(0, 1, 0, 1, 16'($urandom), 0);
        cyc(0, 1, 0, 1, 16'hBEEF, 0);
        cyc(0, 1, 0, 1, 16'h1234, 1);
        cyc(0, 1, 0, 0, 16'h0, 0);

        // Underflow cases, then flush clears sticky flags
        cyc(0, 1, 1, 0, 16'h0, 0);
        cyc(0, 1, 0, 0, 16'h0, 1);
        cyc(0, 1, 0, 1, 16'h7777, 1);
        cyc(0, 1, 1, 1, 16'h5555, 1);

        // Wrap-around with fill held at 3
        for (int k = 0; k < 3; k++) cyc(0, 1, 0, 1, 16'(16'hA000 + k), 0);
        for (int k = 0; k < 600; k++) cyc(0, 1, 0, 1, 16'($urandom), 1);
        cyc(0, 1, 1, 0, 16'h0, 0);

        // Clock-enable freeze, then reset while disabled
        cyc(0, 1, 0, 1, 16'hC001, 0);
        cyc(0, 1, 0, 1, 16'hC002, 0);
        cyc(0, 1, 0, 0, 16'h0, 1);
        for (int k = 0; k < 5; k++) cyc(0, 0, 0, 1, 16'hDEAD, 1);
        cyc(1, 0, 0, 0, 16'h0, 0);
        cyc(0, 1, 0, 0, 16'h0, 0);

        // Registered-output instance: two-cycle latency
        bcyc(1, 0, 0, 8'h00, 0);
        chk("b_rst_count", 32'(b_count), 0);
        chk("b_rst_dout",  32'(b_dout),  0);
        chk("b_rst_vld",   32'(b_vld),   0);
        bcyc(0, 0, 1, 8'hA5, 0);
        chk("b_count_1",   32'(b_count), 1);
        bcyc(0, 0, 0, 8'h00, 1);
        chk("b_vld_lat1",  32'(b_vld),   0);
        chk("b_count_0",   32'(b_count), 0);
        bcyc(0, 0, 0, 8'h00, 0);
        chk("b_vld_lat2",  32'(b_vld),   1);
        chk("b_dout_a5",   32'(b_dout),  32'h A5);
        bcyc(0, 0, 0, 8'h00, 0);
        chk("b_vld_off",   32'(b_vld),   0);
        chk("b_dout_hold", 32'(b_dout),  32'h A5);

        // Flush one cycle after a pop cancels the strobe
        bcyc(0, 0, 1, 8'h5A, 0);
        bcyc(0, 0, 0, 8'h00, 1);
        chk("b_fl_vld0",   32'(b_vld),   0);
        bcyc(0, 1, 0, 8'h00, 0);
        chk("b_fl_vld1",   32'(b_vld),   0);
        chk("b_fl_dout1",  32'(b_dout),  32'h A5);
        chk("b_fl_count",  32'(b_count), 0);
        bcyc(0, 0, 0, 8'h00, 0);
        chk("b_fl_vld2",   32'(b_vld),   0);
        chk("b_fl_dout2",  32'(b_dout),  32'h A5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
